// File: rtl/seg_pkg.sv
// Shared types and defaults for the MEM/WB skid segment.
// Provides the entry layout, the occupancy state enum and the default path widths.
package seg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Field order here is the packing order used for the flat entry vector.
    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [DATA_W_DEF-1:0] mem;
        logic [DATA_W_DEF-1:0] alu;
        logic [REG_AW_DEF-1:0] rr3;
    } mem_wb_entry_t;

    function automatic int entry_width(input int dw, input int aw);
        return 2 + 2 * dw + aw;
    endfunction

endpackage

// File: rtl/segment_mem_wb_skid_if.sv
// MEM->WB handshake bundle: upstream entry, downstream head entry and, with
// SEG_MEM_WB_FWD_EN defined, the forwarding taps.
interface segment_mem_wb_skid_if
    import seg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic              MemToReg_in;
    logic              RegWrite_in;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] alu_in;
    logic [REG_AW-1:0] RR3_in;

    logic              out_valid;
    logic              out_ready;
    logic              MemToReg_out;
    logic              RegWrite_out;
    logic [DATA_W-1:0] mem_out;
    logic [DATA_W-1:0] alu_out;
    logic [REG_AW-1:0] RR3_out;

`ifdef SEG_MEM_WB_FWD_EN
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output in_valid, MemToReg_in, RegWrite_in, mem_in, alu_in, RR3_in, out_ready,
        input  in_ready, out_valid, MemToReg_out, RegWrite_out, mem_out, alu_out, RR3_out,
        input  fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  in_valid, MemToReg_in, RegWrite_in, mem_in, alu_in, RR3_in, out_ready,
        output in_ready, out_valid, MemToReg_out, RegWrite_out, mem_out, alu_out, RR3_out,
        output fwd_valid, fwd_rd, fwd_data
    );
`else
    modport master (
        output in_valid, MemToReg_in, RegWrite_in, mem_in, alu_in, RR3_in, out_ready,
        input  in_ready, out_valid, MemToReg_out, RegWrite_out, mem_out, alu_out, RR3_out
    );

    modport slave (
        input  in_valid, MemToReg_in, RegWrite_in, mem_in, alu_in, RR3_in, out_ready,
        output in_ready, out_valid, MemToReg_out, RegWrite_out, mem_out, alu_out, RR3_out
    );
`endif

endinterface

// File: rtl/seg_entry_reg.sv
// One pipeline entry register with load enable and synchronous clear.
// Updates on the falling edge like every pipeline segment.
module seg_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] entry_d;
    logic [W-1:0] entry_q;

    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            entry_d = '0;
        end else if (load) begin
            entry_d = d;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/segment_mem_wb_skid.sv
// MEM/WB segment with a head register plus one skid register in FIFO order.
// Optional forwarding taps are built only when SEG_MEM_WB_FWD_EN is defined.
module segment_mem_wb_skid
    import seg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  flush,
    segment_mem_wb_skid_if.slave bus
);

    localparam int ENTRY_W = entry_width(DATA_W, REG_AW);

    skid_state_t state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic               push;
    logic               pop;
    logic               head_load;
    logic               skid_load;
    logic               head_from_skid;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_d;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] skid_entry;
    logic               head_mtr;
    logic               head_rw;
    logic               mtr_gated;
    logic               rw_gated;

    assign in_entry = {bus.MemToReg_in, bus.RegWrite_in, bus.mem_in, bus.alu_in, bus.RR3_in};
    assign push     = bus.in_valid & in_ready_q;
    assign pop      = out_valid_q & bus.out_ready;

    // A flush suppresses every load, so a same-cycle push or pop leaves no trace.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign head_d = head_from_skid ? skid_entry : in_entry;

    seg_entry_reg #(.W(ENTRY_W)) u_head (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .load (head_load),
        .d    (head_d),
        .q    (head_entry)
    );

    seg_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .load (skid_load),
        .d    (in_entry),
        .q    (skid_entry)
    );

    assign {head_mtr, head_rw, bus.mem_out, bus.alu_out, bus.RR3_out} = head_entry;

    // Control bits are masked when nothing is valid so a stale head never writes back.
    assign mtr_gated        = head_mtr & out_valid_q;
    assign rw_gated         = head_rw & out_valid_q;
    assign bus.MemToReg_out = mtr_gated;
    assign bus.RegWrite_out = rw_gated;
    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;

`ifdef SEG_MEM_WB_FWD_EN
    assign bus.fwd_valid = out_valid_q & rw_gated;
    assign bus.fwd_rd    = bus.RR3_out;
    assign bus.fwd_data  = mtr_gated ? bus.mem_out : bus.alu_out;
`endif

endmodule

// File: tb/tb_segment_mem_wb_skid.sv
// Directed bench for segment_mem_wb_skid: vector table plus hand-written corner sequences.
// Forwarding checks are compiled in when SEG_MEM_WB_FWD_EN is defined.
module tb_segment_mem_wb_skid;
    import seg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    segment_mem_wb_skid_if #(.DATA_W(32), .REG_AW(4)) bus ();

    segment_mem_wb_skid #(.DATA_W(32), .REG_AW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          rst;
        logic          flush;
        logic          in_valid;
        logic          out_ready;
        mem_wb_entry_t in;
        logic          exp_ov;
        logic          exp_ir;
        logic          chk_data;
        mem_wb_entry_t exp;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic rs, input logic fl, input logic iv, input logic ordy,
        input logic mtr, input logic rw, input logic [31:0] mem, input logic [31:0] alu,
        input logic [3:0] rr3,
        input logic ov, input logic ir, input logic rwo, input logic mtro, input logic chk,
        input logic [31:0] emem, input logic [31:0] ealu, input logic [3:0] err3);
        vec_t v;
        v.rst       = rs;
        v.flush     = fl;
        v.in_valid  = iv;
        v.out_ready = ordy;
        v.in        = '{mem_to_reg: mtr, reg_write: rw, mem: mem, alu: alu, rr3: rr3};
        v.exp_ov    = ov;
        v.exp_ir    = ir;
        v.chk_data  = chk;
        v.exp       = '{mem_to_reg: mtro, reg_write: rwo, mem: emem, alu: ealu, rr3: err3};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input mem_wb_entry_t e);
        bus.in_valid    = iv;
        bus.out_ready   = ordy;
        bus.MemToReg_in = e.mem_to_reg;
        bus.RegWrite_in = e.reg_write;
        bus.mem_in      = e.mem;
        bus.alu_in      = e.alu;
        bus.RR3_in      = e.rr3;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic mem_wb_entry_t ent(input logic mtr, input logic rw,
                                          input logic [31:0] mem, input logic [31:0] alu,
                                          input logic [3:0] rr3);
        return '{mem_to_reg: mtr, reg_write: rw, mem: mem, alu: alu, rr3: rr3};
    endfunction

    initial begin
        //                rst fl iv or mtr rw mem       alu       rr3 | ov ir rwo mtro chk emem      ealu      err3
        // reset, two edges, with live inputs on the second
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,    32'h0,    4'd0,  0, 1, 0, 0, 1, 32'h0,    32'h0,    4'd0);
        vecs[1]  = mk(1, 0, 1, 1, 1, 1, 32'h1234, 32'h5678, 4'd7,  0, 1, 0, 0, 1, 32'h0,    32'h0,    4'd0);
        // streaming 0x10, 0x11, 0x12 then drain
        vecs[2]  = mk(0, 0, 1, 1, 0, 1, 32'h1010, 32'h10,   4'd1,  1, 1, 1, 0, 1, 32'h1010, 32'h10,   4'd1);
        vecs[3]  = mk(0, 0, 1, 1, 1, 1, 32'h1011, 32'h11,   4'd2,  1, 1, 1, 1, 1, 32'h1011, 32'h11,   4'd2);
        vecs[4]  = mk(0, 0, 1, 1, 0, 0, 32'h1012, 32'h12,   4'd3,  1, 1, 0, 0, 1, 32'h1012, 32'h12,   4'd3);
        vecs[5]  = mk(0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    4'd0,  0, 1, 0, 0, 0, 32'h0,    32'h0,    4'd0);
        // backpressure: AA, BB fill, CC refused, then drain
        vecs[6]  = mk(0, 0, 1, 0, 0, 1, 32'h10AA, 32'hAA,   4'd4,  1, 1, 1, 0, 1, 32'h10AA, 32'hAA,   4'd4);
        vecs[7]  = mk(0, 0, 1, 0, 1, 1, 32'h10BB, 32'hBB,   4'd5,  1, 0, 1, 0, 1, 32'h10AA, 32'hAA,   4'd4);
        vecs[8]  = mk(0, 0, 1, 0, 0, 1, 32'h10CC, 32'hCC,   4'd6,  1, 0, 1, 0, 1, 32'h10AA, 32'hAA,   4'd4);
        vecs[9]  = mk(0, 0, 1, 1, 0, 1, 32'h10CC, 32'hCC,   4'd6,  1, 1, 1, 1, 1, 32'h10BB, 32'hBB,   4'd5);
        vecs[10] = mk(0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    4'd0,  0, 1, 0, 0, 0, 32'h0,    32'h0,    4'd0);
        vecs[11] = mk(0, 0, 0, 1, 0, 0, 32'h0,    32'h0,    4'd0,  0, 1, 0, 0, 0, 32'h0,    32'h0,    4'd0);
        // flush while FULL, with a push and pop pending
        vecs[12] = mk(0, 0, 1, 0, 1, 1, 32'h1021, 32'h21,   4'd8,  1, 1, 1, 1, 1, 32'h1021, 32'h21,   4'd8);
        vecs[13] = mk(0, 0, 1, 0, 0, 1, 32'h1022, 32'h22,   4'd9,  1, 0, 1, 1, 1, 32'h1021, 32'h21,   4'd8);
        vecs[14] = mk(0, 1, 1, 1, 1, 1, 32'h1023, 32'h23,   4'd10, 0, 1, 0, 0, 0, 32'h0,    32'h0,    4'd0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 32'h0,    32'h0,    4'd0,  0, 1, 0, 0, 0, 32'h0,    32'h0,    4'd0);
        // reset mid-transfer while FULL with out_ready high
        vecs[16] = mk(0, 0, 1, 0, 1, 1, 32'h1031, 32'h31,   4'd11, 1, 1, 1, 1, 1, 32'h1031, 32'h31,   4'd11);
        vecs[17] = mk(0, 0, 1, 0, 0, 1, 32'h1032, 32'h32,   4'd12, 1, 0, 1, 1, 1, 32'h1031, 32'h31,   4'd11);
        vecs[18] = mk(1, 0, 1, 1, 1, 1, 32'h1033, 32'h33,   4'd13, 0, 1, 0, 0, 1, 32'h0,    32'h0,    4'd0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 32'h0,    32'h0,    4'd0,  0, 1, 0, 0, 1, 32'h0,    32'h0,    4'd0);
        // first push after reset appears after one edge
        vecs[20] = mk(0, 0, 1, 1, 1, 0, 32'h1040, 32'h40,   4'd14, 1, 1, 0, 1, 1, 32'h1040, 32'h40,   4'd14);

        flush = 1'b0;
        rst   = 1'b0;
        drive(1'b0, 1'b0, ent(0, 0, 32'h0, 32'h0, 4'd0));

        for (int i = 0; i < 21; i++) begin
            rst   = vecs[i].rst;
            flush = vecs[i].flush;
            drive(vecs[i].in_valid, vecs[i].out_ready, vecs[i].in);
            step();
            $display("vec %0d: ov=%0b ir=%0b rw=%0b mtr=%0b mem=0x%0h alu=0x%0h rr3=%0d",
                     i, bus.out_valid, bus.in_ready, bus.RegWrite_out, bus.MemToReg_out,
                     bus.mem_out, bus.alu_out, bus.RR3_out);
            check($sformatf("v%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].exp_ov});
            check($sformatf("v%0d_in_ready", i), {31'b0, bus.in_ready}, {31'b0, vecs[i].exp_ir});
            check($sformatf("v%0d_RegWrite_out", i), {31'b0, bus.RegWrite_out},
                  {31'b0, vecs[i].exp.reg_write});
            check($sformatf("v%0d_MemToReg_out", i), {31'b0, bus.MemToReg_out},
                  {31'b0, vecs[i].exp.mem_to_reg});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_mem_out", i), bus.mem_out, vecs[i].exp.mem);
                check($sformatf("v%0d_alu_out", i), bus.alu_out, vecs[i].exp.alu);
                check($sformatf("v%0d_RR3_out", i), {28'b0, bus.RR3_out}, {28'b0, vecs[i].exp.rr3});
            end
        end
        rst   = 1'b0;
        flush = 1'b0;

        // FULL ignores in_valid even while the pop frees a slot in the same cycle.
        drive(1'b1, 1'b0, ent(0, 1, 32'h1051, 32'h51, 4'd1));
        step();
        $display("seq full_fill: ov=%0b ir=%0b alu=0x%0h", bus.out_valid, bus.in_ready, bus.alu_out);
        check("full_fill_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("full_fill_head_alu", bus.alu_out, 32'h40);
        drive(1'b1, 1'b1, ent(0, 1, 32'h1052, 32'h52, 4'd2));
        step();
        $display("seq full_pop: ov=%0b ir=%0b alu=0x%0h", bus.out_valid, bus.in_ready, bus.alu_out);
        check("full_pop_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("full_pop_head_alu", bus.alu_out, 32'h51);
        check("full_pop_rr3", {28'b0, bus.RR3_out}, 32'd1);
        drive(1'b0, 1'b1, ent(0, 0, 32'h0, 32'h0, 4'd0));
        step();
        $display("seq full_drain: ov=%0b ir=%0b", bus.out_valid, bus.in_ready);
        check("full_drain_out_valid", {31'b0, bus.out_valid}, 32'd0);
        step();
        $display("seq full_idle: ov=%0b ir=%0b", bus.out_valid, bus.in_ready);
        check("full_idle_out_valid", {31'b0, bus.out_valid}, 32'd0);

`ifdef SEG_MEM_WB_FWD_EN
        drive(1'b1, 1'b1, ent(1, 1, 32'h1234, 32'h5678, 4'd7));
        step();
        $display("seq fwd_mem: fv=%0b rd=%0d data=0x%0h", bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        check("fwd_mem_valid", {31'b0, bus.fwd_valid}, 32'd1);
        check("fwd_mem_rd", {28'b0, bus.fwd_rd}, 32'd7);
        check("fwd_mem_data", bus.fwd_data, 32'h1234);
        drive(1'b1, 1'b1, ent(0, 1, 32'h1234, 32'h5678, 4'd7));
        step();
        $display("seq fwd_alu: fv=%0b rd=%0d data=0x%0h", bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        check("fwd_alu_valid", {31'b0, bus.fwd_valid}, 32'd1);
        check("fwd_alu_data", bus.fwd_data, 32'h5678);
        drive(1'b1, 1'b1, ent(1, 0, 32'h1234, 32'h5678, 4'd7));
        step();
        $display("seq fwd_norw: fv=%0b rd=%0d data=0x%0h", bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        check("fwd_norw_valid", {31'b0, bus.fwd_valid}, 32'd0);
        drive(1'b0, 1'b1, ent(0, 0, 32'h0, 32'h0, 4'd0));
        step();
        $display("seq fwd_empty: fv=%0b", bus.fwd_valid);
        check("fwd_empty_valid", {31'b0, bus.fwd_valid}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segment_mem_wb_skid.md
SEGMENT_MEM_WB_SKID -- requirements
Module: segment_mem_wb_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of the memory and ALU result paths.
REQ-002 The block SHALL have parameter REG_AW, default 4: width of the destination-register index.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the falling edge, as for every pipeline segment.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: discard all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the MEM stage presents an entry.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an entry this cycle.
REQ-008 The block SHALL have ports MemToReg_in and RegWrite_in, input, 1 bit each: writeback control.
REQ-009 The block SHALL have ports mem_in and alu_in, input, DATA_W bits each: memory and ALU results.
REQ-010 The block SHALL have port RR3_in, input, REG_AW bits: destination register index.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the WB entry is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the WB stage consumes the entry.
REQ-013 The block SHALL have ports MemToReg_out, RegWrite_out, mem_out, alu_out and RR3_out, output, widths matching their inputs: the head entry.

Function
REQ-014 Storage SHALL be a main register (head) plus one skid register, kept in FIFO order.
REQ-015 The state machine SHALL have three states:
- EMPTY
- ONE: head valid.
- FULL: head and skid valid.
REQ-016 A push SHALL occur only when in_valid=1 and in_ready=1.
REQ-017 A pop SHALL occur only when out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL be registered and SHALL equal 1 exactly when the state is not FULL.
REQ-019 out_valid SHALL equal 1 exactly when the state is ONE or FULL.
REQ-020 State transitions SHALL be as follows:
- EMPTY + push -> ONE.
- ONE + push without pop -> FULL.
- ONE + pop without push -> EMPTY.
- ONE + push and pop -> ONE, with the new entry in head.
- FULL + pop -> ONE, with skid moved to head.
- FULL ignores in_valid.
REQ-021 Latency SHALL be one clk falling edge from push to out_valid when the block is EMPTY.
REQ-022 Sustained throughput SHALL be one entry per cycle when out_ready=1.
REQ-023 Whenever out_valid=0, RegWrite_out and MemToReg_out SHALL read 0, so writeback is harmless.
REQ-024 flush SHALL take effect on the next edge: state goes to EMPTY, and any push or pop in the same cycle is discarded.
REQ-025 flush SHALL have priority over push and pop.
REQ-026 Held data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 Payload fields SHALL pass unmodified, with no width conversion.

Reset
REQ-028 While rst=1 at a falling edge, the state SHALL become EMPTY and in_ready SHALL become 1.
REQ-029 After that reset edge, out_valid, MemToReg_out, RegWrite_out, mem_out, alu_out and RR3_out SHALL read 0, and the skid register SHALL be cleared to 0.
REQ-030 rst SHALL have priority over flush, push and pop; reset mid-transfer SHALL discard all entries.

Configuration
REQ-031 With macro SEG_MEM_WB_FWD_EN defined, the block SHALL add the forwarding outputs fwd_valid (1 bit), fwd_rd (REG_AW bits) and fwd_data (DATA_W bits).
REQ-032 With SEG_MEM_WB_FWD_EN defined, fwd_valid SHALL equal out_valid AND RegWrite_out.
REQ-033 With SEG_MEM_WB_FWD_EN defined, fwd_rd SHALL equal RR3_out, and fwd_data SHALL equal mem_out when MemToReg_out=1, else alu_out, all combinational from the head.
REQ-034 Without SEG_MEM_WB_FWD_EN, those ports SHALL be absent and the logic SHALL not be generated.

Structure
REQ-035 A shared package seg_pkg SHALL hold typedef mem_wb_entry_t (the MemToReg, RegWrite, mem, alu and RR3 fields), the state enum (EMPTY/ONE/FULL), and the DATA_W and REG_AW defaults.
REQ-036 Head and skid SHALL each be an instance of one sub-module, seg_entry_reg: an entry register with load enable and clear.

Verification
REQ-037 The bench SHALL cover the following scenarios:
- Reset: hold rst=1 for 2 edges -> out_valid=0, in_ready=1, all outputs 0.
- Streaming: push alu_in=0x10, 0x11, 0x12 on consecutive cycles with out_ready=1 -> out_valid from edge 1; alu_out reads 0x10, 0x11, 0x12 in order; in_ready stays 1.
- Backpressure: out_ready=0, push A=0xAA then B=0xBB -> state FULL, in_ready=0, and a third push of 0xCC is ignored; raise out_ready -> 0xAA, then 0xBB, with 0xCC never appearing.
- Flush: in FULL, assert flush together with in_valid=1 -> next edge out_valid=0, in_ready=1, RegWrite_out=0.
- Forwarding (SEG_MEM_WB_FWD_EN defined): head MemToReg=1, RegWrite=1, mem=0x1234, alu=0x5678, RR3=7 -> fwd_valid=1, fwd_rd=7, fwd_data=0x1234; with RegWrite=0 -> fwd_valid=0.
- Reset mid-transfer: assert rst while FULL with out_ready=1 -> next edge EMPTY, no pop observed.
